rr_sel_arb4: RTL and testbench
==============================

// Module: rr_sel_arb4
// PURPOSE
//  - 4-requester round-robin arbiter. Produces a 2-bit index {sel[1],sel[0]} plus an enable.
//  - Sits directly upstream of the 2-to-4 decoder: sel[1]->a, sel[0]->b, sel_en->en.
//  - The decoder output is therefore the one-hot grant.
//  - Grant is locked until the owner signals done, or until the optional hold timeout fires.
// PARAMETERS
//  - MAX_HOLD  default 8   max GRANT cycles before forced release; legal 2..255.
//    Used only when RR_ARB_TIMEOUT_EN is defined.
// PORTS
//  - clk      in   1  single clock; all state updates on rising edge
//  - rst_n    in   1  reset, synchronous, active-low
//  - req      in   4  request vector, req[i] = requester i; level-sensitive
//  - done     in   1  owner release strobe; sampled only in GRANT
//  - sel      out  2  granted index (MSB->decoder a, LSB->decoder b); registered
//  - sel_en   out  1  grant valid (->decoder en); registered
//  - timeout  out  1  1-cycle pulse on forced release; tied 0 without macro
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, sel=0, sel_en=0, timeout=0, last=3, hold_cnt=0.
//    Reset mid-GRANT drops the grant on that same edge.
//  - States: IDLE, GRANT, RELEASE (2-bit encoding; the unused code returns to IDLE).
//  - Winner: first i with req[i]=1, scanning (last+1)%4, (last+2)%4, ... and wrapping.
//    From reset the scan order is 0,1,2,3.
//  - IDLE: if req!=0, then state=GRANT, sel=winner, sel_en=1 on the next edge.
//    Arbitration latency is 1 cycle. If req==0, stay in IDLE.
//  - GRANT:
//    - sel is held constant and sel_en=1.
//    - req changes are ignored, including the owner dropping req (the grant is locked).
//    - done=1 -> RELEASE: sel_en=0, last=sel. sel keeps its value.
//  - RELEASE: exactly 1 cycle with sel_en=0. This is a guaranteed bubble so the decoder
//    output returns to 0000 between owners.
//    - Arbitrates like IDLE, using the updated last pointer.
//    - req!=0 -> GRANT; req==0 -> IDLE.
//    - Minimum spacing between grants is therefore 1 idle cycle.
//  - done in IDLE or RELEASE: ignored.
//  - done=1 on the GRANT entry cycle: ignored. done is sampled from the first cycle in
//    which sel_en=1 is visible.
//  - Fairness: a requester holding req continuously is granted within 3 other grants.
// CONFIGURATION
//  - Macro RR_ARB_TIMEOUT_EN defined:
//    - 8-bit hold_cnt clears on GRANT entry and increments each GRANT cycle.
//    - In GRANT, if hold_cnt==MAX_HOLD-1 and done==0, go to RELEASE as for done,
//      and timeout=1 for one cycle (aligned with the first RELEASE cycle).
//    - done and the limit in the same cycle: treated as a normal release, timeout stays 0.
//  - Macro RR_ARB_TIMEOUT_EN undefined:
//    - No counter; GRANT is held until done indefinitely.
//    - timeout is constant 0.
// TESTING
//  - Reset, then req=4'b0100 held -> after 1 cycle sel=2, sel_en=1.
//    Then done=1 for 1 cycle -> next cycle sel_en=0.
//  - req=4'b1111 held, done pulsed 2 cycles after each grant -> grant order
//    0,1,2,3,0, with sel_en=0 for exactly 1 cycle between grants.
//  - Owner 1 granted, req drops to 0 with no done -> sel=1, sel_en=1 stays high.
//    done=1 -> release; req still 0 -> IDLE.
//  - rst_n=0 for 1 cycle while sel_en=1 -> next cycle sel_en=0, sel=0.
//    Then req=4'b1000 -> sel=3 (pointer restarted at 3).
//  - RR_ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=4'b0001, done never -> sel_en high
//    exactly 4 cycles, then timeout=1 for 1 cycle, then regrant to 0.
//  - RR_ARB_TIMEOUT_EN defined, MAX_HOLD=4, done=1 on the 4th grant cycle -> release
//    with timeout=0. Without the macro, same stimulus with no done -> sel_en stays
//    high for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_sel_arb4.sv
// rr_sel_arb4: 4-requester round-robin arbiter feeding a 2-to-4 decoder via {sel, sel_en}.
// Optional forced release after MAX_HOLD grant cycles: define RR_ARB_TIMEOUT_EN.
module rr_sel_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       timeout
);

  // state   | meaning
  // IDLE    | no owner; any request is granted on the next edge
  // GRANT   | sel locked to the owner until done (or hold limit)
  // RELEASE | one-cycle bubble with sel_en=0; arbitrates with the updated pointer
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_sel_arb4: MAX_HOLD must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_d;
  logic       sel_en_d;
  logic [1:0] winner;

  // First requester after the last owner, wrapping around.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  assign winner = rr_pick(req, last_q);

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel;
    sel_en_d = 1'b0;
    last_d   = last_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        if (|req) begin
          state_d  = GRANT;
          sel_d    = winner;
          sel_en_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d   = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        sel_en_d = 1'b1;
        if (done) begin
          state_d  = RELEASE;
          sel_en_d = 1'b0;
          last_d   = sel;
`ifdef RR_ARB_TIMEOUT_EN
        end else if (hold_q == HOLD_LAST) begin
          state_d   = RELEASE;
          sel_en_d  = 1'b0;
          last_d    = sel;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel     <= 2'd0;
      sel_en  <= 1'b0;
      last_q  <= 2'd3;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      sel_en  <= sel_en_d;
      last_q  <= last_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_sel_arb4.sv
// Scoreboard bench for rr_sel_arb4: directed per-cycle vectors push expected outputs,
// a monitor pops and compares one entry per clock.
module tb_rr_sel_arb4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       sel_en;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] sel;
    logic       sel_en;
    logic       timeout;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  rr_sel_arb4 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .sel_en  (sel_en),
    .timeout (timeout)
  );

  // Inputs applied for one cycle; expected values are the outputs after the next rising edge.
  task automatic drive(input logic rn, input logic [3:0] r, input logic d,
                       input logic [1:0] es, input logic ee, input logic et,
                       input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req   = r;
    done  = d;
    e.sel     = es;
    e.sel_en  = ee;
    e.timeout = et;
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (sel !== e.sel || sel_en !== e.sel_en || timeout !== e.timeout) begin
          n_fail++;
          $display("FAIL %s: got sel=%0d sel_en=%b timeout=%b, expected sel=%0d sel_en=%b timeout=%b",
                   e.tag, sel, sel_en, timeout, e.sel, e.sel_en, e.timeout);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int grant_order[5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    drive(0, 4'b0000, 0, 2'd0, 0, 0, "reset_0");
    drive(0, 4'b0000, 0, 2'd0, 0, 0, "reset_1");

    // single requester 2, then release and go idle
    drive(1, 4'b0100, 0, 2'd2, 1, 0, "grant2_latency");
    drive(1, 4'b0100, 0, 2'd2, 1, 0, "grant2_hold");
    drive(1, 4'b0000, 1, 2'd2, 0, 0, "grant2_done");
    drive(1, 4'b0000, 0, 2'd2, 0, 0, "grant2_idle");

    // all requesting: rotation 0,1,2,3,0 with a one-cycle bubble
    drive(0, 4'b0000, 0, 2'd0, 0, 0, "reset_rr");
    foreach (grant_order[i]) begin
      drive(1, 4'b1111, 0, 2'(grant_order[i]), 1, 0, "rr_grant");
      drive(1, 4'b1111, 0, 2'(grant_order[i]), 1, 0, "rr_hold");
      drive(1, 4'b1111, 1, 2'(grant_order[i]), 0, 0, "rr_bubble");
    end

    // owner 1: done on entry cycle ignored, req drop ignored while locked
    drive(1, 4'b0010, 1, 2'd1, 1, 0, "entry_done_ignored");
    drive(1, 4'b0000, 0, 2'd1, 1, 0, "locked_req_drop_0");
    drive(1, 4'b0000, 0, 2'd1, 1, 0, "locked_req_drop_1");
    drive(1, 4'b0000, 0, 2'd1, 1, 0, "locked_req_drop_2");
    drive(1, 4'b0000, 1, 2'd1, 0, 0, "locked_release");
    drive(1, 4'b0000, 0, 2'd1, 0, 0, "locked_to_idle");
    drive(1, 4'b0000, 1, 2'd1, 0, 0, "idle_done_ignored");

    // pointer at 1: {3,0} requesting picks 3; reset mid-grant restarts pointer
    drive(1, 4'b1001, 0, 2'd3, 1, 0, "ptr1_pick3");
    drive(1, 4'b1001, 0, 2'd3, 1, 0, "ptr1_hold3");
    drive(0, 4'b1001, 0, 2'd0, 0, 0, "reset_mid_grant");
    drive(1, 4'b1001, 0, 2'd0, 1, 0, "ptr_reset_pick0");
    drive(1, 4'b1001, 1, 2'd0, 0, 0, "ptr_reset_release");
    drive(1, 4'b0000, 0, 2'd0, 0, 0, "ptr_reset_idle");
    drive(0, 4'b0000, 0, 2'd0, 0, 0, "reset_again");
    drive(1, 4'b1000, 0, 2'd3, 1, 0, "after_reset_pick3");
    drive(1, 4'b1000, 1, 2'd3, 0, 0, "pick3_release");
    drive(1, 4'b0000, 0, 2'd3, 0, 0, "pick3_idle");

`ifdef RR_ARB_TIMEOUT_EN
    // MAX_HOLD=4: four grant cycles, then forced release with timeout pulse
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_grant_c1");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_grant_c2");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_grant_c3");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_grant_c4");
    drive(1, 4'b0001, 0, 2'd0, 0, 1, "to_forced_release");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_regrant_c1");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_regrant_c2");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_regrant_c3");
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "to_regrant_c4");
    drive(1, 4'b0001, 1, 2'd0, 0, 0, "done_at_limit_no_timeout");
    drive(1, 4'b0000, 0, 2'd0, 0, 0, "to_idle");
`else
    // no timeout: grant is held indefinitely
    drive(1, 4'b0001, 0, 2'd0, 1, 0, "hold_grant");
    for (int i = 0; i < 110; i++)
      drive(1, 4'b0001, 0, 2'd0, 1, 0, "hold_no_timeout");
    drive(1, 4'b0001, 1, 2'd0, 0, 0, "hold_release");
    drive(1, 4'b0000, 0, 2'd0, 0, 0, "hold_idle");
`endif

    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
